// File: rtl/dense_layer.sv
// dense_layer: fixed-point fully connected layer, one MAC per cycle, streamed inputs and results.
// Weights/biases live in an unreset register file written while idle.
module dense_layer #(
    parameter int N = 16,
    parameter int Q = 8,
    parameter int NUM_INPUTS = 4,
    parameter int NUM_OUTPUTS = 4,
    localparam int AW = $clog2(NUM_OUTPUTS * (NUM_INPUTS + 1)),
    localparam int OW = NUM_OUTPUTS > 1 ? $clog2(NUM_OUTPUTS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [N-1:0]  cfg_data,
    input  logic          relu_en,
    input  logic          start,
    input  logic          in_valid,
    input  logic [N-1:0]  in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [N-1:0]  out_data,
    output logic [OW-1:0] out_idx,
    input  logic          out_ready,
    output logic          busy,
    output logic          done
);
    localparam int DEPTH = NUM_OUTPUTS * (NUM_INPUTS + 1);
    localparam int IW = NUM_INPUTS > 1 ? $clog2(NUM_INPUTS) : 1;
    localparam int ACC_W = 2 * N + $clog2(NUM_INPUTS) + 1;
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);
    localparam logic [IW-1:0] I_LAST = IW'(NUM_INPUTS - 1);
    localparam logic [OW-1:0] O_LAST = OW'(NUM_OUTPUTS - 1);
    localparam logic [AW-1:0] B_BASE = AW'(NUM_OUTPUTS * NUM_INPUTS);
    localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W - N + 1){1'b0}}, {(N - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V = ~MAX_V;

    typedef enum logic [2:0] {IDLE, LOAD, MAC, FIN, OUT, DONE} state_t;
    state_t state, state_n;

    logic signed [N-1:0] mem [DEPTH];
    logic signed [N-1:0] xbuf [NUM_INPUTS];
    logic [IW-1:0] idx;
    logic [OW-1:0] o;
    logic relu;
    logic [AW-1:0] waddr;
    logic signed [N-1:0] w, x, b, r;
    logic signed [2*N-1:0] prod;
    logic signed [ACC_W-1:0] acc, prod_ext, b_ext, sum, shr;
    logic [N-1:0] res;

    assign in_ready  = state == LOAD;
    assign out_valid = state == OUT;
    assign busy      = state != IDLE;
    assign done      = state == DONE;

    assign waddr    = AW'(o) * AW'(NUM_INPUTS) + AW'(idx);
    assign w        = mem[waddr];
    assign x        = xbuf[idx];
    assign b        = mem[B_BASE + AW'(o)];
    // Low 2N bits of the sign-extended product equal the exact signed product.
    assign prod     = {{N{x[N-1]}}, x} * {{N{w[N-1]}}, w};
    assign prod_ext = {{(ACC_W - 2 * N){prod[2*N-1]}}, prod};
    assign b_ext    = {{(ACC_W - N){b[N-1]}}, b};
    assign sum      = acc + (b_ext <<< Q);
    assign shr      = sum >>> Q;
    assign r        = shr > MAX_V ? MAX_V[N-1:0] : shr < MIN_V ? MIN_V[N-1:0] : shr[N-1:0];
    assign res      = (relu && r[N-1]) ? '0 : r;

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (start) state_n = LOAD;
            LOAD: if (in_valid && idx == I_LAST) state_n = MAC;
            MAC:  if (idx == I_LAST) state_n = FIN;
            FIN:  state_n = OUT;
            OUT:  if (out_ready) state_n = (o == O_LAST) ? DONE : MAC;
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            idx      <= '0;
            o        <= '0;
            acc      <= '0;
            relu     <= 1'b0;
            out_data <= '0;
            out_idx  <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && start) relu <= relu_en;
            if ((state == LOAD && in_valid) || state == MAC) idx <= (idx == I_LAST) ? '0 : idx + 1'b1;
            if (state == MAC) acc <= acc + prod_ext;
            else if (state_n == MAC) acc <= '0;
            if (state == LOAD) o <= '0;
            else if (state == OUT && out_ready && o != O_LAST) o <= o + 1'b1;
            if (state == FIN) begin
                out_data <= res;
                out_idx  <= o;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && cfg_we && {1'b0, cfg_addr} < DEPTH_W) mem[cfg_addr] <= cfg_data;
        if (state == LOAD && in_valid) xbuf[idx] <= in_data;
    end
endmodule

// File: doc/dense_layer.md
DENSE_LAYER -- requirements
Module: dense_layer

Interface
REQ-001 SHALL have parameter N, default 16: data word width, signed two's complement fixed point.
REQ-002 SHALL have parameter Q, default 8: fractional bits (Q8.8 at defaults).
REQ-003 SHALL have parameter NUM_INPUTS, default 4: input vector length, >=1.
REQ-004 SHALL have parameter NUM_OUTPUTS, default 4: neuron count, >=1.
REQ-005 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-006 SHALL have ports: reset  in  1  asynchronous, active-low reset.
REQ-007 SHALL have ports: cfg_we  in  1  weight/bias write strobe.
REQ-008 SHALL have ports: cfg_addr  in  AW=clog2(NUM_OUTPUTS*(NUM_INPUTS+1))  0..NO*NI-1 = weight o*NUM_INPUTS+i; NO*NI+o = bias o.
REQ-009 SHALL have ports: cfg_data  in  N  weight/bias value.
REQ-010 SHALL have ports: relu_en  in  1  ReLU enable, sampled on accepted start.
REQ-011 SHALL have ports: start  in  1  begin one inference.
REQ-012 SHALL have ports: in_valid  in  1; in_data  in  N; in_ready  out  1  input element stream.
REQ-013 SHALL have ports: out_valid  out  1; out_data  out  N; out_idx  out  clog2(NUM_OUTPUTS) (min 1); out_ready  in  1  result stream.
REQ-014 SHALL have ports: busy  out  1  high outside IDLE; done  out  1  one-cycle completion pulse.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, MAC, FIN, OUT, DONE.
REQ-016 IDLE: cfg_we writes cfg_data to addressed entry; addresses beyond range ignored; cfg_we outside IDLE ignored.
REQ-017 IDLE + start -> LOAD, latch relu_en; start outside IDLE ignored; cfg_we and start in same cycle: write performed, then start taken.
REQ-018 LOAD: in_ready=1; each in_valid&in_ready stores in_data at next index 0..NUM_INPUTS-1; after last element -> MAC, output index o=0.
REQ-019 MAC: one product per cycle, acc += x[i]*w[o][i], i=0..NUM_INPUTS-1 (NUM_INPUTS cycles); acc cleared at MAC entry per output.
REQ-020 Accumulator width SHALL be 2N+clog2(NUM_INPUTS)+1 signed; no intermediate overflow.
REQ-021 FIN (1 cycle): r = (acc + (bias[o] << Q)) >>> Q (arithmetic shift, truncation toward -inf); saturate to [-2^(N-1), 2^(N-1)-1]; if latched relu_en and r<0, r=0; register to out_data, out_idx=o -> OUT.
REQ-022 OUT: out_valid=1; out_data/out_idx stable until out_valid&out_ready; on handshake, o<NUM_OUTPUTS-1 -> MAC with o+1, else -> DONE.
REQ-023 DONE: done=1 exactly one cycle -> IDLE.
REQ-024 Latency start-accept to first out_valid, with in_valid held high: NUM_INPUTS (LOAD) + NUM_INPUTS (MAC) + 1 (FIN) cycles.
REQ-025 Weights/biases persist across inferences; not altered by inference.

Reset
REQ-026 reset low, any state, asynchronously: FSM->IDLE; in_ready, out_valid, busy, done=0; out_data, out_idx, acc, counters=0; latched relu=0.
REQ-027 Weight/bias storage SHALL NOT be cleared by reset; contents undefined until written.
REQ-028 Reset mid-inference SHALL discard partial results; no out_valid or done until a new start.

Verification
REQ-029 Neuron0 weights 0x0080,0x0100,0x00C0,0xFF80, bias 0x0040; inputs 0x0100,0x0200,0x0300,0x0400; relu off -> out_idx 0, out_data 0x0300 (3.0).
REQ-030 Neuron1 all weights 0xFF00, bias 0; same inputs -> out_data 0xF600 (-10.0) relu off; 0x0000 relu on.
REQ-031 All inputs/weights 0x7F00, bias 0 -> 0x7FFF; weights 0x8100 -> 0x8000 (saturation both rails).
REQ-032 out_ready low 5 cycles during OUT -> out_valid high, out_data/out_idx unchanged; results in order idx 0..3; done one cycle after final handshake.
REQ-033 reset low during MAC of neuron 2 -> all outputs 0 immediately; new start without rewriting weights reproduces REQ-029 result.
REQ-034 in_valid gapped (1 of 3 cycles), cfg_we pulsed while busy -> results identical to REQ-029, weights unchanged.
